// File: rtl/grid_writer.sv
// Write-side controller for the playboard grid status memory: maps pixel clicks
// to cells, applies the PLACE/SHOOT/REMOVE read-modify-write rules and sweeps CLEAR.
module grid_writer #(
  parameter int X_POS   = 0,
  parameter int Y_POS   = 0,
  parameter int COLUMNS = 10,
  parameter int ROWS    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [10:0] cmd_x,
  input  logic [10:0] cmd_y,
  output logic [7:0]  mem_addr,
  input  logic [1:0]  mem_rdata,
  output logic        mem_we,
  output logic [1:0]  mem_wdata,
  output logic        resp_valid,
  output logic        resp_ok,
  output logic [1:0]  resp_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CHK, S_WR, S_CLR, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_PLACE  = 2'd0,
    OP_SHOOT  = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_REMOVE = 2'd3
  } op_t;

  localparam logic [1:0]  EMPTY    = 2'd0;
  localparam logic [1:0]  MYSHIP   = 2'd1;
  localparam logic [1:0]  MISS     = 2'd2;
  localparam logic [1:0]  HIT      = 2'd3;
  localparam logic [10:0] X_ORG    = 11'(X_POS);
  localparam logic [10:0] Y_ORG    = 11'(Y_POS);
  localparam logic [5:0]  COL_LIM  = 6'(COLUMNS);
  localparam logic [5:0]  ROW_LIM  = 6'(ROWS);
  localparam logic [3:0]  LAST_COL = 4'(COLUMNS - 1);
  localparam logic [3:0]  LAST_ROW = 4'(ROWS - 1);

  state_t      state, state_d;
  op_t         op_q, op_d;
  logic [5:0]  col, row;
  logic        in_grid, accept, clr_last;

  logic        cmd_ready_d, mem_we_d, resp_valid_d, resp_ok_d;
  logic [7:0]  mem_addr_d;
  logic [1:0]  mem_wdata_d, resp_code_d;

  // Dropping the low 5 offset bits puts border pixels in their cell; clicks
  // left of / above the origin wrap to huge column/row values.
  assign col      = 6'((cmd_x - X_ORG) >> 5);
  assign row      = 6'((cmd_y - Y_ORG) >> 5);
  assign in_grid  = (col < COL_LIM) && (row < ROW_LIM);
  assign accept   = cmd_valid && cmd_ready;
  assign clr_last = (mem_addr[7:4] == LAST_COL) && (mem_addr[3:0] == LAST_ROW);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= OP_PLACE;
    end else begin
      state <= state_d;
      op_q  <= op_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (op_t'(cmd_op) == OP_CLEAR) state_d = S_CLR;
          else if (in_grid)              state_d = S_RD;
          else                           state_d = S_RESP;
        end
      end
      S_RD:   state_d = S_CHK;
      S_CHK:  state_d = S_WR;
      S_WR:   state_d = S_IDLE;
      S_CLR:  if (clr_last) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    op_d         = op_q;
    cmd_ready_d  = (state_d == S_IDLE);
    mem_addr_d   = mem_addr;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata;
    resp_valid_d = 1'b0;
    resp_ok_d    = resp_ok;
    resp_code_d  = resp_code;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          op_d = op_t'(cmd_op);
          if (op_t'(cmd_op) == OP_CLEAR) begin
            mem_addr_d  = 8'h00;
            mem_we_d    = 1'b1;
            mem_wdata_d = EMPTY;
          end else if (in_grid) begin
            mem_addr_d = {col[3:0], row[3:0]};
          end else begin
            resp_valid_d = 1'b1;
            resp_ok_d    = 1'b0;
            resp_code_d  = EMPTY;
          end
        end
      end
      S_CHK: begin
        resp_valid_d = 1'b1;
        resp_ok_d    = 1'b0;
        resp_code_d  = mem_rdata;
        case (op_q)
          OP_PLACE: begin
            if (mem_rdata == EMPTY) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = MYSHIP;
              resp_ok_d   = 1'b1;
              resp_code_d = MYSHIP;
            end
          end
          OP_REMOVE: begin
            if (mem_rdata == MYSHIP) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = EMPTY;
              resp_ok_d   = 1'b1;
              resp_code_d = EMPTY;
            end
          end
          OP_SHOOT: begin
            if (mem_rdata == EMPTY) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = MISS;
              resp_ok_d   = 1'b1;
              resp_code_d = MISS;
            end else if (mem_rdata == MYSHIP) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = HIT;
              resp_ok_d   = 1'b1;
              resp_code_d = HIT;
            end
          end
          default: ;
        endcase
      end
      S_CLR: begin
        if (clr_last) begin
          resp_valid_d = 1'b1;
          resp_ok_d    = 1'b1;
          resp_code_d  = EMPTY;
        end else begin
          mem_we_d    = 1'b1;
          mem_wdata_d = EMPTY;
          if (mem_addr[3:0] == LAST_ROW) mem_addr_d = {mem_addr[7:4] + 4'd1, 4'd0};
          else                           mem_addr_d = {mem_addr[7:4], mem_addr[3:0] + 4'd1};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b0;
      mem_addr   <= 8'h00;
      mem_we     <= 1'b0;
      mem_wdata  <= 2'd0;
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
      resp_code  <= 2'd0;
    end else begin
      cmd_ready  <= cmd_ready_d;
      mem_addr   <= mem_addr_d;
      mem_we     <= mem_we_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_ok    <= resp_ok_d;
      resp_code  <= resp_code_d;
    end
  end

endmodule

// File: doc/grid_writer.md
Name: grid_writer

Overview:
- Write-side controller for the playboard grid status memory. The pixel-side VGA drawer is the only reader of that memory; this block is the only writer.
- Accepts cursor/click commands in VGA pixel coordinates and maps them to cells using the same addressing as the drawer: addr = {col[3:0], row[3:0]}.
- Applies the game-rule read-modify-write and reports the result to the game FSM.
- Sits between the mouse/game control logic and the grid RAM write port. The RAM read port shared with the drawer is not touched.

Parameters:
- X_POS, 0, pixel x of grid origin (same value as the drawer instance).
- Y_POS, 0, pixel y of grid origin.
- COLUMNS, 10, number of grid columns (max 16).
- ROWS, 10, number of grid rows (max 16).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  command: 0=PLACE, 1=SHOOT, 2=CLEAR, 3=REMOVE.
- cmd_x  in  11  pixel x (hcount domain).
- cmd_y  in  11  pixel y (vcount domain).
- mem_addr  out  8  grid RAM address {col,row}.
- mem_rdata  in  2  grid RAM read data; 1-cycle read latency.
- mem_we  out  1  grid RAM write enable.
- mem_wdata  out  2  grid RAM write data.
- resp_valid  out  1  one-cycle result pulse.
- resp_ok  out  1  1 = command had an effect.
- resp_code  out  2  resulting cell status.

Behaviour:
- Status encoding: EMPTY=0, MYSHIP=1, MISS=2, HIT=3.
- All outputs are registered.
- Reset values: cmd_ready=0 while rst_n=0, then 1 in the first cycle after release. mem_addr=0, mem_we=0, mem_wdata=0, resp_valid=0, resp_ok=0, resp_code=0. State=IDLE.
- Reset mid-operation aborts immediately. No further writes occur, and a partial CLEAR stays partial.
- Handshake: accept when cmd_valid & cmd_ready. cmd_ready=1 only in IDLE. Inputs are sampled only on accept.
- Cell mapping: ox = cmd_x - X_POS, oy = cmd_y - Y_POS (11-bit wrap). col = ox[10:5], row = oy[10:5].
- In-grid means col < COLUMNS and row < ROWS. Clicks left of or above the origin wrap to large values and therefore fall outside the grid.
- Border pixels (ox[4:0] < border width) count as inside the cell.
- FSM states: IDLE, RD, CHK, WR, CLR, RESP.
- Cell op, in-grid, accepted at edge E0:
  - E0 registers mem_addr={col[3:0],row[3:0]}; state RD.
  - E1: state CHK.
  - E2: samples mem_rdata, evaluates the rule, registers mem_we/mem_wdata and resp_*; state WR.
  - Cycle after E2: mem_we (if a write is due) and resp_valid are both high for exactly 1 cycle.
  - Next edge: IDLE. Accept-to-resp latency = 3 cycles; back-to-back commands need 4 cycles.
- Rules (rdata -> write / resp_ok / resp_code):
  - PLACE: EMPTY -> write MYSHIP, ok=1, code=1. Any other status: no write, ok=0, code=rdata.
  - REMOVE: MYSHIP -> write EMPTY, ok=1, code=0. Otherwise: no write, ok=0, code=rdata.
  - SHOOT: EMPTY -> write MISS, ok=1, code=2. MYSHIP -> write HIT, ok=1, code=3. MISS/HIT: no write, ok=0, code=rdata (repeated shot).
- Cell op, out of grid: IDLE -> RESP. resp_valid=1 one cycle after accept with ok=0, code=0. No RAM access and mem_we stays 0.
- CLEAR (x,y ignored):
  - State CLR writes EMPTY, with mem_we=1 every cycle for COLUMNS*ROWS consecutive cycles.
  - Address order: col 0..COLUMNS-1 outer, row 0..ROWS-1 inner (0x00, 0x01, ... 0x09, 0x10, ...).
  - Cells outside COLUMNS x ROWS are never written.
  - After the last write: one RESP cycle with resp_valid=1, ok=1, code=0.
- mem_we is never high outside WR/CLR. mem_addr holds its last value when idle.
- cmd_valid held high while cmd_ready=0 is ignored and not queued.

Test Plan:
1. X_POS=64, Y_POS=96, empty RAM; PLACE x=170, y=260 -> mem_addr=8'h35 one cycle after accept; mem_we=1, wdata=1, resp_valid, ok=1, code=1 three cycles after accept.
2. PLACE again at same cell -> no mem_we; ok=0, code=1. Then SHOOT there -> write 3, ok=1, code=3. SHOOT again -> ok=0, code=3.
3. SHOOT on empty cell x=64, y=96 (addr 8'h00) -> write 2, code=2. REMOVE on it -> ok=0, no write.
4. PLACE x=40 (left of origin) and x=64+10*32=384 -> resp_valid one cycle after accept, ok=0, mem_we never asserted.
5. CLEAR with COLUMNS=ROWS=10 -> exactly 100 consecutive writes of 0 with the ordered address sequence ending at 8'h99, then resp ok=1. Hold cmd_valid throughout -> cmd_ready=0 and no extra accepts.
6. Assert rst_n=0 asynchronously mid-CLEAR at write 37 -> mem_we=0 and resp_valid=0 immediately. cmd_ready=1 the cycle after release, and RAM cells beyond write 37 are unchanged.
